// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core sequencer: FSM states, halt codes, reset PC.
package core_seq_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        IWAIT = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        MWAIT = 3'd4,
        WB    = 3'd5,
        HALT  = 3'd6
    } seq_state_e;

    localparam logic [1:0] HALT_NONE      = 2'd0;
    localparam logic [1:0] HALT_ZERO_INST = 2'd1;
    localparam logic [1:0] HALT_MISALIGN  = 2'd2;

endpackage

// File: rtl/core_seq_perf.sv
// Free-running cycle and retired-instruction counters; only built when CORE_SEQ_PERF_EN is defined.
module core_seq_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_en,
    input  logic        retire,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (count_en) cycle_cnt <= cycle_cnt + 64'd1;
            if (retire) instret_cnt <= instret_cnt + 64'd1;
        end
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/exec/mem/write-back sequencer owning PC and IR.
// Optional perf counters are enabled with `define CORE_SEQ_PERF_EN.
import core_seq_pkg::*;

module core_seq_ctrl #(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    input  logic            dec_mem,
    input  logic            dec_wb,
    input  logic [XLEN-1:0] next_pc,
    output logic            rf_we,
    output logic            halted,
    output logic [1:0]      halt_code,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt,
    output logic [2:0]      state_dbg
);

    // Handshake: a request is held (with a stable address) until its grant is
    // sampled; data/ack arrives with rvalid in the grant cycle or any later
    // cycle, and no new request on the same port is issued before that rvalid.

    seq_state_e state, nxt;
    logic [1:0] nxt_code;
    logic       capture;

    always_comb begin
        nxt      = state;
        nxt_code = halt_code;
        case (state)
            FETCH: if (imem_req && imem_gnt) nxt = imem_rvalid ? EXEC : IWAIT;
            IWAIT: if (imem_rvalid) nxt = EXEC;
            EXEC: begin
                if (inst == 32'd0) begin
                    nxt      = HALT;
                    nxt_code = HALT_ZERO_INST;
                end else if (next_pc[1:0] != 2'b00) begin
                    nxt      = HALT;
                    nxt_code = HALT_MISALIGN;
                end else if (dec_mem) begin
                    nxt = MEM;
                end else begin
                    nxt = WB;
                end
            end
            MEM:   if (dmem_req && dmem_gnt) nxt = dmem_rvalid ? WB : MWAIT;
            MWAIT: if (dmem_rvalid) nxt = WB;
            WB:    nxt = FETCH;
            HALT:  nxt = HALT;
            default: nxt = HALT;
        endcase
    end

    // An instruction response is only meaningful after our own grant.
    assign capture = (state == FETCH && imem_req && imem_gnt && imem_rvalid) ||
                     (state == IWAIT && imem_rvalid);

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            inst      <= '0;
            imem_req  <= 1'b0;
            dmem_req  <= 1'b0;
            rf_we     <= 1'b0;
            halted    <= 1'b0;
            halt_code <= HALT_NONE;
        end else begin
            state     <= nxt;
            imem_req  <= (nxt == FETCH);
            dmem_req  <= (nxt == MEM);
            rf_we     <= (nxt == WB) && dec_wb;
            halted    <= (nxt == HALT);
            halt_code <= nxt_code;
            if (capture) inst <= imem_rdata;
            if (state == WB) pc <= next_pc;
        end
    end

    assign imem_addr = pc;
    assign state_dbg = state;

`ifdef CORE_SEQ_PERF_EN
    core_seq_perf u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .count_en    (!halted),
        .retire      (state == WB),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: acts as instruction/data memory and
// predicts latency, PC and write strobes from the architectural sequencing rules.
module tb_core_seq_ctrl;
  import core_seq_pkg::*;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk, rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_gnt, dmem_rvalid;
  logic [63:0] pc, next_pc;
  logic [31:0] inst;
  logic        dec_mem, dec_wb, rf_we, halted;
  logic [1:0]  halt_code;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [2:0]  state_dbg;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_pc;
  int          exp_ret;

  core_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .pc(pc), .inst(inst), .dec_mem(dec_mem), .dec_wb(dec_wb), .next_pc(next_pc),
    .rf_we(rf_we), .halted(halted), .halt_code(halt_code),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    dmem_gnt = 0; dmem_rvalid = 0;
    dec_mem = 0; dec_wb = 0; next_pc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_pc  = RPC;
    exp_ret = 0;
  endtask

  // driver: runs one instruction as memory, returns what it observed.
  // Cycle 1 is the cycle imem_gnt is driven high.
  task automatic exec_instr(input logic [31:0] iw, input logic mem, input logic wb,
                            input logic [63:0] npc, input int gdly, input int rdly,
                            input int dgd, input int drd,
                            output int nf, output int rf_cnt, output int rf_cyc,
                            output int halt_cyc, output int pc_chg, output int stall_bad,
                            output int dreq_cyc, output logic [63:0] pc_end);
    int w, d0;
    logic [63:0] pc0;
    nf = 0; rf_cnt = 0; rf_cyc = 0; halt_cyc = 0; pc_chg = 0; stall_bad = 0;
    dreq_cyc = 0; d0 = -1; pc0 = pc; w = 0;
    @(negedge clk);
    while (!imem_req && w < 20) begin
      w++;
      @(negedge clk);
    end
    for (int s = 0; s < gdly; s++) begin
      if (!imem_req || imem_addr !== exp_pc) stall_bad++;
      imem_gnt = 0;
      @(negedge clk);
    end
    imem_rdata = iw; dec_mem = mem; dec_wb = wb; next_pc = npc;
    for (int c = 1; c <= 200; c++) begin
      if (c == 1) begin
        if (!imem_req || imem_addr !== exp_pc) stall_bad++;
        pc0 = pc;
      end else begin
        if (rf_we) begin rf_cnt++; rf_cyc = c; end
        if (pc_chg == 0 && pc !== pc0) pc_chg = c;
        if (dmem_req) begin dreq_cyc++; if (d0 < 0) d0 = c; end
        if (imem_req) begin nf = c; break; end
        if (halted) begin halt_cyc = c; break; end
      end
      imem_gnt    = (c == 1);
      imem_rvalid = (c == rdly + 1);
      dmem_gnt    = (d0 >= 0 && c == d0 + dgd);
      dmem_rvalid = (d0 >= 0 && c == d0 + dgd + drd);
      @(negedge clk);
    end
    pc_end = pc;
    idle_inputs();
  endtask

  // reference latency: fetch + iwait + exec + mem/mwait + wb, then next fetch
  function automatic int model_nf(input logic mem, input int rdly, input int dgd, input int drd);
    return 1 + rdly + 1 + (mem ? (dgd + 1 + drd) : 0) + 1 + 1;
  endfunction

  task automatic test_reset();
    int w;
    idle_inputs();
    rst_n = 0;
    #23;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_imem_req: got %0b expected 0", imem_req); end
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_dmem_req: got %0b expected 0", dmem_req); end
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %0b expected 0", rf_we); end
    n_vec++; if (pc !== RPC) begin n_err++; $display("FAIL reset_pc: got %0h expected %0h", pc, RPC); end
    n_vec++; if (inst !== 32'd0) begin n_err++; $display("FAIL reset_inst: got %0h expected 0", inst); end
    n_vec++; if (halted !== 1'b0 || halt_code !== HALT_NONE) begin n_err++; $display("FAIL reset_halt: got %0b/%0d expected 0/0", halted, halt_code); end
    n_vec++; if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt); end
    @(negedge clk);
    rst_n = 1;
    exp_pc = RPC; exp_ret = 0;
    w = 0;
    while (!imem_req && w < 5) begin w++; @(negedge clk); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin n_err++; $display("FAIL first_fetch: got req=%0b addr=%0h expected req=1 addr=%0h", imem_req, imem_addr, RPC); end
  endtask

  task automatic test_basic();
    int nf, rc, rcy, hc, pch, sb, dq; logic [63:0] pe;
    exec_instr(32'h00100093, 0, 1, exp_pc + 64'd4, 0, 1, 0, 0, nf, rc, rcy, hc, pch, sb, dq, pe);
    n_vec++; if (sb !== 0) begin n_err++; $display("FAIL basic_addr: got %0d bad cycles expected 0", sb); end
    n_vec++; if (rc !== 1 || rcy !== 4) begin n_err++; $display("FAIL basic_rf_we: got %0d pulses at cycle %0d expected 1 at 4", rc, rcy); end
    n_vec++; if (nf !== 5 || pe !== 64'h8000_0004) begin n_err++; $display("FAIL basic_pc: got pc=%0h at cycle %0d expected 80000004 at 5", pe, nf); end
    exp_pc = exp_pc + 64'd4; exp_ret++;
  endtask

  task automatic test_back_to_back();
    int nf, rc, rcy, hc, pch, sb, dq; logic [63:0] pe;
    exec_instr(32'h00208113, 0, 1, exp_pc + 64'd4, 0, 0, 0, 0, nf, rc, rcy, hc, pch, sb, dq, pe);
    n_vec++; if (nf !== 4 || rcy !== 3) begin n_err++; $display("FAIL b2b_latency: got next fetch %0d rf_we %0d expected 4/3", nf, rcy); end
    exp_pc = exp_pc + 64'd4; exp_ret++;
    exec_instr(32'h00310193, 0, 1, exp_pc + 64'd4, 3, 0, 0, 0, nf, rc, rcy, hc, pch, sb, dq, pe);
    n_vec++; if (sb !== 0) begin n_err++; $display("FAIL stall_hold: got %0d bad cycles expected 0", sb); end
    n_vec++; if (nf !== 4 || pe !== exp_pc + 64'd4) begin n_err++; $display("FAIL stall_retire: got pc=%0h cycle %0d expected %0h cycle 4", pe, nf, exp_pc + 64'd4); end
    exp_pc = exp_pc + 64'd4; exp_ret++;
  endtask

  task automatic test_store();
    int nf, rc, rcy, hc, pch, sb, dq; logic [63:0] pe;
    exec_instr(32'h00a12023, 1, 0, exp_pc + 64'd4, 0, 1, 2, 1, nf, rc, rcy, hc, pch, sb, dq, pe);
    n_vec++; if (rc !== 0) begin n_err++; $display("FAIL store_rf_we: got %0d pulses expected 0", rc); end
    n_vec++; if (dq !== 3) begin n_err++; $display("FAIL store_dmem_req: got %0d cycles expected 3", dq); end
    n_vec++; if (nf !== model_nf(1, 1, 2, 1) || pch !== nf) begin n_err++; $display("FAIL store_pc_timing: got fetch %0d pc change %0d expected %0d", nf, pch, model_nf(1, 1, 2, 1)); end
    n_vec++; if (pe !== exp_pc + 64'd4) begin n_err++; $display("FAIL store_pc: got %0h expected %0h", pe, exp_pc + 64'd4); end
    exp_pc = exp_pc + 64'd4; exp_ret++;
  endtask

  task automatic test_random();
    int nf, rc, rcy, hc, pch, sb, dq; logic [63:0] pe, npc;
    logic [31:0] iw; logic mem, wb; int gd, rd, dg, dr;
    for (int i = 0; i < 40; i++) begin
      iw  = $urandom | 32'h1;
      mem = 1'($urandom_range(0, 1));
      wb  = 1'($urandom_range(0, 1));
      gd  = $urandom_range(0, 2); rd = $urandom_range(0, 3);
      dg  = $urandom_range(0, 3); dr = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) npc = {$urandom, $urandom} & ~64'h3;
      else npc = exp_pc + 64'd4;
      exec_instr(iw, mem, wb, npc, gd, rd, dg, dr, nf, rc, rcy, hc, pch, sb, dq, pe);
      n_vec++;
      if (nf !== model_nf(mem, rd, dg, dr) || rc !== int'(wb) || pe !== npc || pch !== nf ||
          sb !== 0 || dq !== (mem ? dg + 1 : 0) || (wb && rcy !== nf - 1)) begin
        n_err++;
        $display("FAIL random_%0d: got fetch=%0d rf=%0d pc=%0h chg=%0d bad=%0d dreq=%0d expected fetch=%0d rf=%0d pc=%0h",
                 i, nf, rc, pe, pch, sb, dq, model_nf(mem, rd, dg, dr), wb, npc);
      end
      exp_pc = npc; exp_ret++;
    end
  endtask

  task automatic test_wrap();
    int nf, rc, rcy, hc, pch, sb, dq; logic [63:0] pe;
    exec_instr(32'h0000006f, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, nf, rc, rcy, hc, pch, sb, dq, pe);
    exp_pc = 64'hFFFF_FFFF_FFFF_FFFC; exp_ret++;
    exec_instr(32'h00000013, 0, 0, exp_pc + 64'd4, 0, 0, 0, 0, nf, rc, rcy, hc, pch, sb, dq, pe);
    n_vec++; if (pe !== 64'd0 || sb !== 0) begin n_err++; $display("FAIL pc_wrap: got %0h expected 0", pe); end
    exp_pc = 64'd0; exp_ret++;
  endtask

  task automatic test_misalign();
    int nf, rc, rcy, hc, pch, sb, dq, bad; logic [63:0] pe;
    do_reset();
    exec_instr(32'h00100093, 0, 1, exp_pc + 64'd4, 0, 1, 0, 0, nf, rc, rcy, hc, pch, sb, dq, pe);
    exp_pc = exp_pc + 64'd4; exp_ret++;
    // jal that also claims a memory access: misalignment must win
    exec_instr(32'h0fc0_00ef, 1, 1, 64'h8000_0102, 0, 1, 0, 0, nf, rc, rcy, hc, pch, sb, dq, pe);
    n_vec++; if (hc !== 4 || halt_code !== HALT_MISALIGN) begin n_err++; $display("FAIL misalign_halt: got halt cycle %0d code %0d expected 4/2", hc, halt_code); end
    n_vec++; if (rc !== 0 || dq !== 0) begin n_err++; $display("FAIL misalign_strobes: got rf=%0d dreq=%0d expected 0/0", rc, dq); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      imem_gnt = 1'($urandom_range(0, 1)); imem_rvalid = 1'($urandom_range(0, 1));
      dmem_gnt = 1'($urandom_range(0, 1)); dmem_rvalid = 1'($urandom_range(0, 1));
      dec_wb = 1; next_pc = exp_pc + 64'd4;
      @(negedge clk);
      if (imem_req || dmem_req || rf_we || !halted || pc !== 64'h8000_0004) bad++;
    end
    idle_inputs();
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL halt_absorb: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_zero();
    int nf, rc, rcy, hc, pch, sb, dq, k; logic [63:0] pe, c0;
    do_reset();
    k = $urandom_range(2, 5);
    for (int i = 0; i < k; i++) begin
      exec_instr($urandom | 32'h1, 0, 1, exp_pc + 64'd4, 0, $urandom_range(0, 2), 0, 0,
                 nf, rc, rcy, hc, pch, sb, dq, pe);
      exp_pc = exp_pc + 64'd4; exp_ret++;
    end
    // zero instruction outranks a misaligned next_pc
    exec_instr(32'h0, 0, 1, 64'h3, 0, 0, 0, 0, nf, rc, rcy, hc, pch, sb, dq, pe);
    n_vec++; if (halted !== 1'b1 || halt_code !== HALT_ZERO_INST || hc !== 3) begin n_err++; $display("FAIL zero_halt: got halted=%0b code=%0d cycle=%0d expected 1/1/3", halted, halt_code, hc); end
    n_vec++; if (rc !== 0 || pe !== exp_pc) begin n_err++; $display("FAIL zero_commit: got rf=%0d pc=%0h expected 0/%0h", rc, pe, exp_pc); end
    c0 = cycle_cnt;
    repeat (5) @(negedge clk);
`ifdef CORE_SEQ_PERF_EN
    n_vec++; if (instret_cnt !== 64'(exp_ret)) begin n_err++; $display("FAIL instret: got %0d expected %0d", instret_cnt, exp_ret); end
    n_vec++; if (cycle_cnt !== c0 || cycle_cnt == 64'd0) begin n_err++; $display("FAIL cycle_freeze: got %0d expected %0d (nonzero)", cycle_cnt, c0); end
`else
    n_vec++; if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0 || c0 !== 64'd0) begin n_err++; $display("FAIL counters_tied: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt); end
`endif
  endtask

  task automatic test_reset_mwait();
    int w, bad, seen;
    do_reset();
    w = 0;
    @(negedge clk);
    while (!imem_req && w < 10) begin w++; @(negedge clk); end
    imem_gnt = 1; imem_rvalid = 1; imem_rdata = 32'h0001_3083;
    dec_mem = 1; dec_wb = 1; next_pc = RPC + 64'd4;
    @(negedge clk);
    imem_gnt = 0; imem_rvalid = 0;
    w = 0;
    while (!dmem_req && w < 10) begin w++; @(negedge clk); end
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    repeat (2) @(negedge clk);
    n_vec++; if (state_dbg !== 3'(MWAIT)) begin n_err++; $display("FAIL reach_mwait: got state %0d expected %0d", state_dbg, MWAIT); end
    rst_n = 0;
    #1;
    n_vec++; if (dmem_req || imem_req || rf_we || halted || pc !== RPC || inst !== 32'd0) begin
      n_err++; $display("FAIL async_reset: got dreq=%0b ireq=%0b rf=%0b pc=%0h inst=%0h expected 0/0/0/%0h/0", dmem_req, imem_req, rf_we, pc, inst, RPC);
    end
    @(negedge clk);
    rst_n = 1;
    bad = 0; seen = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_rvalid = 1; imem_rvalid = 1; imem_rdata = 32'hdead_beef;
      @(negedge clk);
      if (rf_we || dmem_req || pc !== RPC) bad++;
      if (imem_req && imem_addr === RPC) seen++;
    end
    idle_inputs();
    n_vec++; if (bad !== 0 || inst !== 32'd0) begin n_err++; $display("FAIL late_response: got %0d bad cycles inst=%0h expected 0/0", bad, inst); end
    n_vec++; if (seen == 0) begin n_err++; $display("FAIL refetch_addr: got no fetch at %0h expected one", RPC); end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_store();
    test_random();
    test_wrap();
    test_misalign();
    test_zero();
    test_reset_mwait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the RV64 core datapath (decoder, adder, regfile, PC).
- Owns the PC and instruction register.
- Runs the fetch/execute/memory/write-back order over request/grant/valid memory handshakes.
- Gates the regfile write enable and PC update so each instruction commits exactly once.
- Halts on an all-zero instruction or a misaligned next PC.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
XLEN, 64, PC/address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request; held until imem_gnt
imem_addr  out  XLEN  fetch address (= pc)
imem_gnt  in  1  fetch request accepted
imem_rvalid  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
dmem_req  out  1  data access request; held until dmem_gnt
dmem_gnt  in  1  data request accepted
dmem_rvalid  in  1  data access complete (load data or store ack)
pc  out  XLEN  current instruction PC
inst  out  32  instruction register (to decoder)
dec_mem  in  1  decoded instruction accesses data memory (load/store)
dec_wb  in  1  decoded instruction writes rd
next_pc  in  XLEN  next PC computed by datapath (pc+4 or branch/jump target)
rf_we  out  1  regfile write strobe, one-cycle pulse
halted  out  1  core stopped (sticky until reset)
halt_code  out  2  0 = running, 1 = zero instruction, 2 = misaligned next_pc
cycle_cnt  out  64  cycle counter (optional feature)
instret_cnt  out  64  retired-instruction counter (optional feature)

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc = RESET_PC, inst = 0, state = FETCH.
  - All request/strobe outputs 0; halted = 0, halt_code = 0; counters 0.
- Moore FSM; outputs decode from state only.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_gnt: if imem_rvalid is also high, capture imem_rdata into inst and go to EXEC; else go to IWAIT.
- IWAIT: on imem_rvalid, capture inst and go to EXEC. imem_rvalid in any other state is ignored.
- EXEC: one cycle for decode and datapath settle. Priority order:
  1. inst == 0: go to HALT, halt_code = 1.
  2. next_pc[1:0] != 0: go to HALT, halt_code = 2.
  3. dec_mem: go to MEM.
  4. Otherwise go to WB.
- MEM: dmem_req = 1 until dmem_gnt. Gnt with rvalid in the same cycle goes to WB; gnt alone goes to MWAIT.
- MWAIT: on dmem_rvalid, go to WB.
- WB:
  - rf_we = dec_wb for exactly this cycle; pc <= next_pc registered at the end of WB.
  - instret increments; go to FETCH.
- HALT:
  - Absorbing until reset; halted = 1.
  - No requests, no rf_we pulses, pc frozen.
- Handshake rules:
  - Each req stays high and its address stays stable until gnt.
  - At most one outstanding access per port; a new request is never issued before the prior rvalid.
- Latency:
  - Non-memory instruction with gnt in the first FETCH cycle and rvalid one cycle later: 4 cycles (FETCH, IWAIT, EXEC, WB).
  - Same-cycle gnt+rvalid: 3 cycles.
  - Memory instructions add MEM (+MWAIT).
- Stalls: an arbitrary number of cycles of gnt or rvalid low holds the state; no timeout.
- PC arithmetic: XLEN-bit, wraps modulo 2^XLEN with no flag.
- rf_we is never asserted outside WB, including during reset or HALT.
- Reset mid-transaction drops any outstanding access. Responses still in flight after reset are ignored until the next grant.

Optional Feature:
CORE_SEQ_PERF_EN
- Defined:
  - cycle_cnt increments every cycle after reset while not halted.
  - instret_cnt increments once per WB.
  - Both are 64-bit and wrap.
- Undefined: both ports tied to 0 and no counter flops are synthesised.

Decomposition:
- Package core_seq_pkg:
  - State enum: FETCH, IWAIT, EXEC, MEM, MWAIT, WB, HALT.
  - halt_code constants: HALT_NONE = 0, HALT_ZERO_INST = 1, HALT_MISALIGN = 2.
  - Default RESET_PC.
- One sub-module, core_seq_perf: the two counters, instantiated only under CORE_SEQ_PERF_EN.

Test Plan:
1. Reset then release; gnt immediate, rvalid next cycle; inst = 32'h00100093 (addi), dec_wb = 1, next_pc = pc+4 -> imem_addr = 64'h8000_0000, single rf_we pulse in cycle 4, pc = 64'h8000_0004 in cycle 5.
2. Same-cycle gnt+rvalid, then 3 cycles of gnt low on the next fetch -> first instruction retires in 3 cycles; imem_req held and imem_addr stable through the stall.
3. Store (dec_mem = 1, dec_wb = 0), dmem_gnt after 2 cycles, rvalid after 1 more -> no rf_we pulse; pc advances only after dmem_rvalid.
4. jal with next_pc = 64'h8000_0102 -> HALT, halt_code = 2, no rf_we pulse, pc stays at the jal address, no further imem_req.
5. inst = 32'h0 -> halted = 1, halt_code = 1; with CORE_SEQ_PERF_EN, cycle_cnt frozen and instret_cnt equals the count of prior retirements.
6. rst_n low while in MWAIT -> outputs cleared immediately; late dmem_rvalid ignored; first fetch after release at 64'h8000_0000.
